// File: rtl/seg_run_ctrl_if.sv
// seg_run_ctrl_if
// Purpose: groups the control inputs and the position outputs of the
// running-block sequencer into one bundle.
// Signals:
//   start      - one-cycle pulse, begin or resume running
//   stop       - one-cycle pulse, pause (a second stop returns to idle)
//   dir        - 0 = forward 1->8, 1 = reverse 8->1
//   speed[1:0] - step period = TICK_DIV >> speed
//   sel[3:0]   - block position 1..8 for the segment decoder
//   dig_en[3:0]- one-hot digit enable, bit0 = leftmost digit
//   step_pulse - one-cycle strobe coincident with each sel update
//   running    - high while the sequencer is running
// Modports: master drives the controls, slave is the sequencer.
interface seg_run_ctrl_if;
  logic       start;
  logic       stop;
  logic       dir;
  logic [1:0] speed;
  logic [3:0] sel;
  logic [3:0] dig_en;
  logic       step_pulse;
  logic       running;

  modport master (
    output start, stop, dir, speed,
    input  sel, dig_en, step_pulse, running
  );

  modport slave (
    input  start, stop, dir, speed,
    output sel, dig_en, step_pulse, running
  );
endinterface

// File: rtl/seg_run_ctrl.sv
// seg_run_ctrl
// Purpose: position sequencer for the 7-segment running-block animation.
// Steps sel through 1..8 at a programmable rate and produces the matching
// one-hot digit enable so the block runs along the upper row left-to-right
// and back along the lower row right-to-left.
// Ports:
//   sys_clk - system clock, all logic on the rising edge
//   sys_rst - asynchronous active-high reset
//   bus     - seg_run_ctrl_if.slave (controls in, position/strobes out)
// Parameters:
//   TICK_DIV - clock cycles per step at speed 0 (>= 8, multiple of 8)
//   CNT_W    - prescaler width, must hold TICK_DIV-1
module seg_run_ctrl #(
  parameter int TICK_DIV = 10_000_000,
  parameter int CNT_W    = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  seg_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TICK_DIV_C = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       sel_reg, sel_next;
  logic [3:0]       dig_en_reg, dig_en_next;
  logic             step_pulse_reg, step_pulse_next;
  logic             running_reg, running_next;

  logic [CNT_W-1:0] period_m1;
  logic             sel_legal;

  // TICK_DIV is a multiple of 8, so every shifted period is exact and >= 1.
  assign period_m1 = (TICK_DIV_C >> bus.speed) - ONE_C;
  assign sel_legal = (sel_reg != 4'd0) && (sel_reg <= 4'd8);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    sel_next        = sel_reg;
    step_pulse_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // stop has priority over start; stop alone is a no-op here
        if (!bus.stop && bus.start) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_next = PAUSE;
        end else if (cnt_reg >= period_m1) begin
          // ">=" so a speed change to a shorter period steps at once
          cnt_next        = '0;
          step_pulse_next = 1'b1;
          if (bus.dir) begin
            sel_next = (sel_reg == 4'd1) ? 4'd8 : sel_reg - 4'd1;
          end else begin
            sel_next = (sel_reg == 4'd8) ? 4'd1 : sel_reg + 4'd1;
          end
        end else begin
          cnt_next = cnt_reg + ONE_C;
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_next = IDLE;
          sel_next   = 4'd1;
          cnt_next   = '0;
        end else if (bus.start) begin
          // resume from the frozen count, no clear
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = 4'd1;
        cnt_next   = '0;
      end
    endcase

    // A corrupted position is repaired on the next clock without a strobe.
    if (!sel_legal) begin
      sel_next        = 4'd1;
      step_pulse_next = 1'b0;
    end

    running_next = (state_next == RUN);
  end

  // Digit gi is lit for the upper-row position gi+1 and for the lower-row
  // position 8-gi, which walks the lower row right-to-left.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dig
    assign dig_en_next[gi] = (sel_next == 4'(gi + 1)) || (sel_next == 4'(8 - gi));
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      sel_reg        <= 4'd1;
      dig_en_reg     <= 4'b0001;
      step_pulse_reg <= 1'b0;
      running_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      sel_reg        <= sel_next;
      dig_en_reg     <= dig_en_next;
      step_pulse_reg <= step_pulse_next;
      running_reg    <= running_next;
    end
  end

  assign bus.sel        = sel_reg;
  assign bus.dig_en     = dig_en_reg;
  assign bus.step_pulse = step_pulse_reg;
  assign bus.running    = running_reg;

endmodule

// File: tb/tb_seg_run_ctrl.sv
// tb_seg_run_ctrl
// Purpose: directed bench for seg_run_ctrl with TICK_DIV=8. A behavioural
// model (mode, run cycles since the last step, ring position 0..7) predicts
// every registered output; a compare process checks it on each falling edge,
// and literal expectations at key points pin the model itself.
module tb_seg_run_ctrl;

  logic clk;
  logic rst;

  int checks;
  int errors;

  seg_run_ctrl_if bus ();

  seg_run_ctrl #(
    .TICK_DIV (8),
    .CNT_W    (32)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 run, 2 pause. pos is the ring index, sel = pos+1.
  int m_mode;
  int m_elapsed;
  int m_pos;
  bit m_pulse;
  int dig_tbl [8] = '{1, 2, 4, 8, 8, 4, 2, 1};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode    <= 0;
      m_elapsed <= 0;
      m_pos     <= 0;
      m_pulse   <= 1'b0;
    end else begin
      m_pulse <= 1'b0;
      if (m_mode == 0) begin
        if (bus.start && !bus.stop) begin
          m_mode    <= 1;
          m_elapsed <= 0;
        end
      end else if (m_mode == 1) begin
        if (bus.stop) begin
          m_mode <= 2;
        end else if (m_elapsed + 1 >= (8 >> bus.speed)) begin
          m_elapsed <= 0;
          m_pulse   <= 1'b1;
          m_pos     <= (m_pos + (bus.dir ? 7 : 1)) % 8;
        end else begin
          m_elapsed <= m_elapsed + 1;
        end
      end else begin
        if (bus.stop) begin
          m_mode    <= 0;
          m_pos     <= 0;
          m_elapsed <= 0;
        end else if (bus.start) begin
          m_mode <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_sel", int'(bus.sel), m_pos + 1);
      chk("model_dig_en", int'(bus.dig_en), dig_tbl[m_pos]);
      chk("model_step_pulse", int'(bus.step_pulse), int'(m_pulse));
      chk("model_running", int'(bus.running), (m_mode == 1) ? 1 : 0);
      if (bus.step_pulse)
        $display("step sel=%0d dig_en=%b dir=%0d speed=%0d", bus.sel, bus.dig_en, bus.dir, bus.speed);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int fwd_sel [8] = '{2, 3, 4, 5, 6, 7, 8, 1};
  int fwd_dig [8] = '{2, 4, 8, 8, 4, 2, 1, 1};
  int rev_sel [5] = '{3, 2, 1, 8, 7};
  int rev_dig [5] = '{4, 2, 1, 1, 2};

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.dir   = 1'b0;
    bus.speed = 2'd0;
    ticks(2);
    chk("reset_sel", int'(bus.sel), 1);
    chk("reset_dig_en", int'(bus.dig_en), 1);
    chk("reset_running", int'(bus.running), 0);
    chk("reset_step_pulse", int'(bus.step_pulse), 0);
    rst = 1'b0;
    ticks(2);

    // forward run, one full lap
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("first_running", int'(bus.running), 1);
    for (int s = 0; s < 8; s++) begin
      ticks(7);
      chk("fwd_pre_pulse", int'(bus.step_pulse), 0);
      tick();
      chk("fwd_pulse", int'(bus.step_pulse), 1);
      chk("fwd_sel", int'(bus.sel), fwd_sel[s]);
      chk("fwd_dig_en", int'(bus.dig_en), fwd_dig[s]);
    end

    // forward to sel=4, then reverse
    ticks(24);
    chk("at_sel4", int'(bus.sel), 4);
    bus.dir = 1'b1;
    for (int s = 0; s < 5; s++) begin
      ticks(8);
      chk("rev_sel", int'(bus.sel), rev_sel[s]);
      chk("rev_dig_en", int'(bus.dig_en), rev_dig[s]);
    end
    bus.dir = 1'b0;

    // pause at cnt=5, hold, resume, then stop twice
    ticks(5);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk("pause_running", int'(bus.running), 0);
    ticks(20);
    chk("pause_sel", int'(bus.sel), 7);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("resume_running", int'(bus.running), 1);
    ticks(2);
    chk("resume_no_pulse", int'(bus.step_pulse), 0);
    tick();
    chk("resume_pulse", int'(bus.step_pulse), 1);
    chk("resume_sel", int'(bus.sel), 8);
    bus.stop = 1'b1; ticks(2); bus.stop = 1'b0;
    chk("idle_sel", int'(bus.sel), 1);
    chk("idle_dig_en", int'(bus.dig_en), 1);
    chk("idle_running", int'(bus.running), 0);

    // speed 3: step every cycle with wrap
    bus.speed = 2'd3;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    ticks(8);
    chk("fast_pulse", int'(bus.step_pulse), 1);
    chk("fast_wrap_sel", int'(bus.sel), 1);
    bus.stop = 1'b1; ticks(2); bus.stop = 1'b0;

    // speed change mid-count: steps on the very next cycle
    bus.speed = 2'd0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    ticks(6);
    bus.speed = 2'd2;
    tick();
    chk("speedup_pulse", int'(bus.step_pulse), 1);
    chk("speedup_sel", int'(bus.sel), 2);
    tick();
    chk("speedup_gap", int'(bus.step_pulse), 0);
    tick();
    chk("speedup_pulse2", int'(bus.step_pulse), 1);
    chk("speedup_sel2", int'(bus.sel), 3);
    bus.stop = 1'b1; ticks(2); bus.stop = 1'b0;
    bus.speed = 2'd0;

    // start+stop together: idle stays idle, run goes to pause
    bus.start = 1'b1; bus.stop = 1'b1; tick(); bus.start = 1'b0; bus.stop = 1'b0;
    chk("both_idle", int'(bus.running), 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    ticks(3);
    bus.start = 1'b1; bus.stop = 1'b1; tick(); bus.start = 1'b0; bus.stop = 1'b0;
    chk("both_run", int'(bus.running), 0);
    ticks(2);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("both_resume", int'(bus.running), 1);
    ticks(10);

    // asynchronous reset between edges mid-run
    #3;
    rst = 1'b1;
    #1;
    chk("arst_sel", int'(bus.sel), 1);
    chk("arst_dig_en", int'(bus.dig_en), 1);
    chk("arst_running", int'(bus.running), 0);
    chk("arst_step_pulse", int'(bus.step_pulse), 0);
    tick();
    rst = 1'b0;
    ticks(10);
    chk("no_restart", int'(bus.running), 0);

    // corrupted position is repaired on the next clock
    @(negedge clk);
    #1;
    dut.sel_reg = 4'd0;
    #1;
    chk("deposit_sel", int'(bus.sel), 0);
    tick();
    chk("repair_sel", int'(bus.sel), 1);
    chk("repair_pulse", int'(bus.step_pulse), 0);
    ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_run_ctrl.md
Name: seg_run_ctrl

Overview:
- Position sequencer for the 7-segment "running block" animation.
- Steps a block position index sel through 1..8 at a programmable rate.
- Drives sel straight into the downstream segment decoder, which shows the upper square for sel 1-4 and the lower square for sel 5-8.
- Also produces the matching one-hot digit enable, so the block circulates: upper row left-to-right, then lower row right-to-left.

Parameters:
- TICK_DIV, 10_000_000, base clock cycles per step at speed=0 (200 ms at 50 MHz). Must be >= 8 and a multiple of 8.
- CNT_W, 32, prescaler counter width. Must hold TICK_DIV-1.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse: begin or resume running.
- stop  input  1  single-cycle pulse: pause; a second stop returns to idle.
- dir  input  1  0 = forward (1→8), 1 = reverse (8→1). Sampled only at a step.
- speed  input  2  step period select: TICK_DIV >> speed.
- sel  output  4  block position, always in 1..8; feeds the segment decoder.
- dig_en  output  4  one-hot digit enable, active-high, bit0 = leftmost digit.
- step_pulse  output  1  one-cycle strobe, coincident with each sel update.
- running  output  1  high while in RUN.

Behaviour:
- Reset (async, on assertion): state=IDLE, cnt=0, sel=4'd1, dig_en=4'b0001, step_pulse=0, running=0.
- All outputs are registered.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start → RUN; cnt cleared to 0.
  - RUN + stop → PAUSE; cnt and sel frozen.
  - PAUSE + start → RUN; cnt resumes from its frozen value, with no clear.
  - PAUSE + stop → IDLE; sel←1, cnt←0.
  - start and stop in the same cycle: stop wins; the transition is as if stop alone.
  - start in RUN and stop in IDLE are ignored.
- running=1 exactly when state=RUN. It rises the cycle after start is sampled.
- Prescaler:
  - period = TICK_DIV >> speed.
  - In RUN, cnt increments each cycle.
  - When cnt >= period-1: cnt←0, step occurs.
  - The ">=" compare means a speed change to a shorter period mid-count steps on the next cycle, never skips.
  - In IDLE and PAUSE cnt does not increment.
- Step:
  - dir=0: sel←sel+1, with 8 wrapping to 1.
  - dir=1: sel←sel-1, with 1 wrapping to 8.
  - step_pulse=1 for that single cycle, same edge as the new sel.
  - dig_en updates on the same edge.
- dig_en mapping:
  - sel=1 → 0001, sel=2 → 0010, sel=3 → 0100, sel=4 → 1000.
  - sel=5 → 1000, sel=6 → 0100, sel=7 → 0010, sel=8 → 0001.
- sel never takes 0 or 9-15. Any illegal value (e.g. an SEU) is forced to 1 on the next clock.
- First-step latency from IDLE: start sampled at edge N → RUN at N+1 → first step at edge N+period.
- Reset asserted mid-RUN: immediate return to reset values. Operation restarts only on a new start.

Test Plan:
Sim build uses TICK_DIV=8.
- Reset, then start at cycle 0, speed=0, dir=0 → step_pulse at cycles 8,16,…; sel sequence 2,3,4,5,6,7,8,1; dig_en 0010,0100,1000,1000,0100,0010,0001,0001; running=1 from cycle 1.
- Forward run; at sel=4, hold dir=1 → next steps give sel 3,2,1,8,7; dig_en tracks the mapping table.
- RUN with cnt=5, then stop → sel and cnt frozen, step_pulse stays 0 for 20 cycles; then start → next step exactly 3 cycles after RUN re-entry. A second stop from PAUSE → sel=1, dig_en=0001, running=0.
- speed=3 (period 1) → step_pulse high every cycle, sel wraps 8→1. At cnt=6 with speed=0, switch to speed=2 → step on the very next cycle, then every 2 cycles.
- start and stop in the same cycle while IDLE → stays IDLE. In RUN → PAUSE. Assert sys_rst asynchronously mid-RUN, between clock edges → sel=1, dig_en=0001, running=0, step_pulse=0 immediately.
- Force sel=4'd0 via hierarchical deposit → sel=1 on the next clock; no step_pulse generated.
